// File: rtl/innings_controller.sv
// innings_controller
// Match-state engine feeding the LED/ball-count display and seven-segment paths.
// It counts runs, wickets and legal balls for each team, sequences the two
// innings with a timed break between them, and declares the winner.
// Optional feature macro: FREE_HIT_EN. When it is defined, a no-ball arms a
// free hit, and a wicket code on the free-hit delivery counts as a dot ball.
//
// state | meaning
// ------+---------------------------------------------------------------
// BAT1  | team1 batting; deliveries accepted
// BREAK | inning break; down-counter running; deliveries ignored
// BAT2  | team2 batting (chasing); deliveries accepted
// OVER  | match finished; winner latched; everything frozen until reset
module innings_controller #(
    parameter int BALLS_PER_INNING   = 12,
    parameter int WICKETS_PER_INNING = 3,
    parameter int BREAK_CYCLES       = 50_000_000
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic       delivery,
    input  logic [3:0] lfsr_out,
    output logic       teamSwitch,
    output logic       inningOver,
    output logic       gameOver,
    output logic [6:0] ballCount,
    output logic [7:0] team1Runs,
    output logic [7:0] team2Runs,
    output logic [3:0] team1Wkts,
    output logic [3:0] team2Wkts,
    output logic [3:0] lastOutcome,
    output logic [1:0] winner
);

    localparam int CW = $clog2(BREAK_CYCLES + 1);

    typedef enum logic [1:0] {
        BAT1  = 2'd0,
        BREAK = 2'd1,
        BAT2  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_break_cnt;
    logic            r_team_switch;
    logic            r_inning_over;
    logic            r_game_over;
    logic [6:0]      r_ball_count;
    logic [7:0]      r_team1_runs;
    logic [7:0]      r_team2_runs;
    logic [3:0]      r_team1_wkts;
    logic [3:0]      r_team2_wkts;
    logic [3:0]      r_last_outcome;
    logic [1:0]      r_winner;
`ifdef FREE_HIT_EN
    logic            r_free_hit;
`endif

    logic [3:0]      w_runs_add;
    logic            w_legal;
    logic            w_wicket;
    logic            w_no_ball;
    logic            w_free_hit;
    logic [7:0]      w_cur_runs;
    logic [3:0]      w_cur_wkts;
    logic [8:0]      w_sum;
    logic [7:0]      w_runs_new;
    logic [3:0]      w_wkts_new;
    logic [6:0]      w_balls_new;
    logic            w_balls_done;
    logic            w_wkts_done;

`ifdef FREE_HIT_EN
    assign w_free_hit = r_free_hit;
`else
    assign w_free_hit = 1'b0;
`endif

    // Outcome decode: runs to add, whether the ball is legal, whether it takes a wicket
    always_comb begin
        w_runs_add = 4'd0;
        w_legal    = 1'b1;
        w_wicket   = 1'b0;
        w_no_ball  = 1'b0;
        case (lfsr_out)
            4'd2, 4'd3, 4'd4: w_runs_add = 4'd1;
            4'd5, 4'd6:       w_runs_add = 4'd2;
            4'd7:             w_runs_add = 4'd3;
            4'd8, 4'd9:       w_runs_add = 4'd4;
            4'd10, 4'd11:     w_runs_add = 4'd6;
            4'd12:            w_wicket   = ~w_free_hit;
            4'd13: begin
                w_runs_add = 4'd1;
                w_legal    = 1'b0;
            end
            4'd14: begin
                w_runs_add = 4'd1;
                w_legal    = 1'b0;
                w_no_ball  = 1'b1;
            end
            default: w_runs_add = 4'd0;
        endcase
    end

    // Post-delivery values for whichever team is batting; runs saturate at 255
    always_comb begin
        w_cur_runs   = (r_state == BAT2) ? r_team2_runs : r_team1_runs;
        w_cur_wkts   = (r_state == BAT2) ? r_team2_wkts : r_team1_wkts;
        w_sum        = {1'b0, w_cur_runs} + {5'd0, w_runs_add};
        w_runs_new   = w_sum[8] ? 8'hFF : w_sum[7:0];
        w_wkts_new   = w_cur_wkts + {3'd0, w_wicket};
        w_balls_new  = r_ball_count + {6'd0, w_legal};
        w_balls_done = (w_balls_new == 7'(BALLS_PER_INNING));
        w_wkts_done  = (w_wkts_new == 4'(WICKETS_PER_INNING));
    end

    // Match FSM with all outputs registered alongside the state
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            r_state        <= BAT1;
            r_break_cnt    <= '0;
            r_team_switch  <= 1'b0;
            r_inning_over  <= 1'b0;
            r_game_over    <= 1'b0;
            r_ball_count   <= 7'd0;
            r_team1_runs   <= 8'd0;
            r_team2_runs   <= 8'd0;
            r_team1_wkts   <= 4'd0;
            r_team2_wkts   <= 4'd0;
            r_last_outcome <= 4'd0;
            r_winner       <= 2'b00;
`ifdef FREE_HIT_EN
            r_free_hit     <= 1'b0;
`endif
        end else begin
            case (r_state)
                BAT1: begin
                    if (delivery) begin
                        r_last_outcome <= lfsr_out;
                        r_ball_count   <= w_balls_new;
                        r_team1_runs   <= w_runs_new;
                        r_team1_wkts   <= w_wkts_new;
`ifdef FREE_HIT_EN
                        if (w_no_ball)
                            r_free_hit <= 1'b1;
                        else if (w_legal)
                            r_free_hit <= 1'b0;
`endif
                        if (w_balls_done || w_wkts_done) begin
                            r_state       <= BREAK;
                            r_inning_over <= 1'b1;
                            r_break_cnt   <= CW'(BREAK_CYCLES - 1);
`ifdef FREE_HIT_EN
                            r_free_hit    <= 1'b0;
`endif
                        end
                    end
                end
                BREAK: begin
                    if (r_break_cnt == '0) begin
                        r_state       <= BAT2;
                        r_team_switch <= 1'b1;
                        r_inning_over <= 1'b0;
                        r_ball_count  <= 7'd0;
                    end else begin
                        r_break_cnt <= r_break_cnt - CW'(1);
                    end
                end
                BAT2: begin
                    if (delivery) begin
                        r_last_outcome <= lfsr_out;
                        r_ball_count   <= w_balls_new;
                        r_team2_runs   <= w_runs_new;
                        r_team2_wkts   <= w_wkts_new;
`ifdef FREE_HIT_EN
                        if (w_no_ball)
                            r_free_hit <= 1'b1;
                        else if (w_legal)
                            r_free_hit <= 1'b0;
`endif
                        // Chase is checked first so an extra can still win the match
                        if ((w_runs_new > r_team1_runs) || w_balls_done || w_wkts_done) begin
                            r_state       <= OVER;
                            r_inning_over <= 1'b1;
                            r_game_over   <= 1'b1;
`ifdef FREE_HIT_EN
                            r_free_hit    <= 1'b0;
`endif
                            if (w_runs_new > r_team1_runs)
                                r_winner <= 2'b10;
                            else if (w_runs_new < r_team1_runs)
                                r_winner <= 2'b01;
                            else
                                r_winner <= 2'b11;
                        end
                    end
                end
                default: begin
                    r_state <= OVER;
                end
            endcase
        end
    end

    // The no-ball decode only feeds the free-hit flag; keep it referenced otherwise
    logic w_unused;
    assign w_unused = w_no_ball & 1'b0;

    assign teamSwitch  = r_team_switch;
    assign inningOver  = r_inning_over;
    assign gameOver    = r_game_over;
    assign ballCount   = r_ball_count;
    assign team1Runs   = r_team1_runs;
    assign team2Runs   = r_team2_runs;
    assign team1Wkts   = r_team1_wkts;
    assign team2Wkts   = r_team2_wkts;
    assign lastOutcome = r_last_outcome;
    assign winner      = r_winner;

endmodule
